// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and limits for the fetch/data memory port arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam int MEM_LAT_MAX = 4;

    // Clamp a requested latency into the supported 1..MEM_LAT_MAX window
    function automatic int clamp_lat(input int lat);
        if (lat < 1)
            return 1;
        else if (lat > MEM_LAT_MAX)
            return MEM_LAT_MAX;
        else
            return lat;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signal bundle of the port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // hazard-unit stalls
    logic              stall_f_o;
    logic              stall_m_o;

    // Pipeline stages and memory model view
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_f_o, stall_m_o
    );

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_f_o, stall_m_o
    );
endinterface

// File: rtl/mem_port_arbiter_lat_timer.sv
// rtl/mem_port_arbiter_lat_timer.sv - loadable latency down-counter with completion flag
import arb_pkg::*;

module arb_lat_timer #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int CNT_W = $clog2(LAT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load on issue, count down while a transaction is in flight
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = CNT_W'(LAT);
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Counter register; cleared on reset so an aborted transfer leaves nothing behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Completion is the cycle whose decrement lands on zero
    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch and load/store (optional ARB_PERF_CNT_EN counters)
import arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0] conflict_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    mem_port_arbiter_if.slave bus
);
    localparam int LAT = clamp_lat(MEM_LAT);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    grant_t            grant;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              issue;
    logic              lat_done;
    logic              if_valid;
    logic              d_valid;

    // Data wins a tie unless it won the previous grant
    assign grant = (bus.d_req && (!bus.if_req || (last_grant_q == GNT_FETCH))) ? GNT_DATA : GNT_FETCH;
    // Reset gates the issue strobe so an asserted reset never launches a transfer
    assign issue = (state_q == IDLE) && (bus.if_req || bus.d_req) && !reset;

    arb_lat_timer #(.LAT(LAT)) u_lat_timer (
        .clk    (clk),
        .rst    (reset),
        .load_i (issue),
        .dec_i  (state_q != IDLE),
        .done_o (lat_done)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: grant from IDLE, return to IDLE in the completion cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = (grant == GNT_DATA) ? BUSY_D : BUSY_I;
            BUSY_I,
            BUSY_D:  if (lat_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: memory issue fields and completion pulses
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if_valid      = 1'b0;
        d_valid       = 1'b0;
        if (issue) begin
            bus.mem_en = 1'b1;
            if (grant == GNT_DATA) begin
                bus.mem_we    = bus.d_we;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_we ? bus.d_wdata : '0;
            end else begin
                bus.mem_addr  = bus.if_addr;
            end
        end
        if (state_q == BUSY_I && lat_done)
            if_valid = 1'b1;
        if (state_q == BUSY_D && lat_done)
            d_valid = 1'b1;
    end

    // Next values of the side registers: grant history, store flag, captured read data
    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if (issue) begin
            last_grant_d = grant;
            we_d         = (grant == GNT_DATA) && bus.d_we;
        end
        if (if_valid)
            if_rdata_d = bus.mem_rdata;
        if (d_valid && !we_q)
            d_rdata_d = bus.mem_rdata;
    end

    // Side registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GNT_FETCH;
            we_q         <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.if_valid  = if_valid;
    assign bus.d_valid   = d_valid;
    // Read data is forwarded in the completion cycle, then held from the capture register
    assign bus.if_rdata  = if_valid ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rdata   = (d_valid && !we_q) ? bus.mem_rdata : d_rdata_q;
    assign bus.stall_f_o = bus.if_req & ~if_valid;
    assign bus.stall_m_o = bus.d_req & ~d_valid;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counts of tie cycles and stalled cycles
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if ((state_q == IDLE) && bus.if_req && bus.d_req && (conflict_cnt_q != '1))
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        if ((bus.stall_f_o || bus.stall_m_o) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule
